// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared opcodes, framing constants and FSM state types
// for the UART calculator and its serial sub-blocks.
package uart_alu_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;

   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_NOR = 6'h27;
   localparam logic [5:0] OP_SRA = 6'h03;
   localparam logic [5:0] OP_SRL = 6'h02;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {GET_A, GET_B, GET_OP} col_state_t;

endpackage

// File: rtl/uart_alu_serdes_rx.sv
// uart_alu_serdes_rx: 8N1 receiver, LSB first, 16x oversampled.
// A byte with a low stop bit is dropped and the line must return high
// before the next start bit is accepted.
module uart_alu_serdes_rx
   import uart_alu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       s_tick,
   output logic       rx_done,
   output logic [7:0] rx_data
);

   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] HALF_TICK = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

   rx_state_t  state;
   logic [3:0] s_cnt;
   logic [2:0] n_cnt;
   logic [7:0] shreg;
   logic       brk;

   assign rx_data = shreg;

   // Receive state machine: mid-bit sampling, framing-error recovery via brk
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RX_IDLE;
         s_cnt   <= '0;
         n_cnt   <= '0;
         shreg   <= '0;
         brk     <= 1'b0;
         rx_done <= 1'b0;
      end else begin
         rx_done <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (!rx) begin
                  state <= RX_START;
                  s_cnt <= '0;
               end
            end
            RX_START: begin
               if (s_tick) begin
                  if (s_cnt == HALF_TICK) begin
                     s_cnt <= '0;
                     n_cnt <= '0;
                     state <= rx ? RX_IDLE : RX_DATA;
                  end else begin
                     s_cnt <= s_cnt + 4'd1;
                  end
               end
            end
            RX_DATA: begin
               if (s_tick) begin
                  if (s_cnt == LAST_TICK) begin
                     s_cnt <= '0;
                     shreg <= {rx, shreg[7:1]};
                     if (n_cnt == LAST_BIT) state <= RX_STOP;
                     else                   n_cnt <= n_cnt + 3'd1;
                  end else begin
                     s_cnt <= s_cnt + 4'd1;
                  end
               end
            end
            RX_STOP: begin
               if (brk) begin
                  if (rx) begin
                     brk   <= 1'b0;
                     state <= RX_IDLE;
                  end
               end else if (s_tick) begin
                  if (s_cnt == LAST_TICK) begin
                     s_cnt <= '0;
                     if (rx) begin
                        rx_done <= 1'b1;
                        state   <= RX_IDLE;
                     end else begin
                        brk <= 1'b1;
                     end
                  end else begin
                     s_cnt <= s_cnt + 4'd1;
                  end
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_alu_top.sv
// uart_alu_top: UART calculator. Receives A, B, opcode as 8N1 bytes and
// transmits the 8-bit ALU result. Define UART_ALU_SHIFT_OPS_EN to build
// the SRA/SRL shift opcodes; otherwise they return 0x00.
module uart_alu_top
   import uart_alu_pkg::*;
#(
   parameter int TICK_DIV = 326
) (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   output logic tx
);

   localparam int         CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

   logic [CW-1:0] tick_cnt;
   logic          s_tick;
   logic [1:0]    rx_sync;
   logic          rx_done;
   logic [7:0]    rx_data;

   col_state_t    col_state;
   logic [7:0]    a, b;
   logic [5:0]    op;
   logic          res_valid;
   logic [7:0]    alu_out;

   logic [7:0]    result;
   logic          slot_full;
   logic          tx_start;
   logic          tx_free;

   tx_state_t     tx_state;
   logic          tx_pend;
   logic [7:0]    tx_shreg;
   logic [3:0]    tx_scnt;
   logic [2:0]    tx_ncnt;
   logic          tx_done;

   assign s_tick = (tick_cnt == CW'(TICK_DIV - 1));

   // Oversampling tick generator
   always_ff @(posedge clk) begin
      if (reset || s_tick) tick_cnt <= '0;
      else                 tick_cnt <= tick_cnt + CW'(1);
   end

   // Two-flop synchronizer on the serial input
   always_ff @(posedge clk) begin
      if (reset) rx_sync <= '1;
      else       rx_sync <= {rx_sync[0], rx};
   end

   uart_alu_serdes_rx u_rx (
      .clk     (clk),
      .reset   (reset),
      .rx      (rx_sync[1]),
      .s_tick  (s_tick),
      .rx_done (rx_done),
      .rx_data (rx_data)
   );

   // Operand collector: A, B, then opcode; flags a complete set
   always_ff @(posedge clk) begin
      if (reset) begin
         col_state <= GET_A;
         a         <= '0;
         b         <= '0;
         op        <= '0;
         res_valid <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         if (rx_done) begin
            case (col_state)
               GET_A: begin
                  a         <= rx_data;
                  col_state <= GET_B;
               end
               GET_B: begin
                  b         <= rx_data;
                  col_state <= GET_OP;
               end
               GET_OP: begin
                  op        <= rx_data[5:0];
                  col_state <= GET_A;
                  res_valid <= 1'b1;
               end
               default: col_state <= GET_A;
            endcase
         end
      end
   end

   // ALU on the collected operands
   always_comb begin
      alu_out = '0;
      case (op)
         OP_ADD: alu_out = a + b;
         OP_SUB: alu_out = a - b;
         OP_AND: alu_out = a & b;
         OP_OR:  alu_out = a | b;
         OP_XOR: alu_out = a ^ b;
         OP_NOR: alu_out = ~(a | b);
`ifdef UART_ALU_SHIFT_OPS_EN
         OP_SRA: alu_out = 8'($signed(a) >>> b[2:0]);
         OP_SRL: alu_out = a >> b[2:0];
`endif
         default: alu_out = '0;
      endcase
   end

   // tx_done marks the cycle the transmitter has just gone idle
   assign tx_free = tx_done || (tx_state == TX_IDLE && !tx_pend && !tx_start);

   // Result register doubles as the single pending slot; newer results overwrite
   always_ff @(posedge clk) begin
      if (reset) begin
         result    <= '0;
         slot_full <= 1'b0;
         tx_start  <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         if (res_valid) begin
            result    <= alu_out;
            slot_full <= 1'b1;
         end else if (slot_full && tx_free) begin
            tx_start  <= 1'b1;
            slot_full <= 1'b0;
         end
      end
   end

   // Transmitter: start bit aligned to the next tick, then 16 ticks per bit
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_pend  <= 1'b0;
         tx_shreg <= '0;
         tx_scnt  <= '0;
         tx_ncnt  <= '0;
         tx_done  <= 1'b0;
         tx       <= 1'b1;
      end else begin
         tx_done <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               tx <= 1'b1;
               if (tx_start) begin
                  tx_pend  <= 1'b1;
                  tx_shreg <= result;
               end else if (tx_pend && s_tick) begin
                  tx_pend  <= 1'b0;
                  tx_scnt  <= '0;
                  tx       <= 1'b0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (s_tick) begin
                  if (tx_scnt == LAST_TICK) begin
                     tx_scnt  <= '0;
                     tx_ncnt  <= '0;
                     tx       <= tx_shreg[0];
                     tx_state <= TX_DATA;
                  end else begin
                     tx_scnt <= tx_scnt + 4'd1;
                  end
               end
            end
            TX_DATA: begin
               if (s_tick) begin
                  if (tx_scnt == LAST_TICK) begin
                     tx_scnt <= '0;
                     if (tx_ncnt == LAST_BIT) begin
                        tx       <= 1'b1;
                        tx_state <= TX_STOP;
                     end else begin
                        tx_ncnt  <= tx_ncnt + 3'd1;
                        tx_shreg <= {1'b0, tx_shreg[7:1]};
                        tx       <= tx_shreg[1];
                     end
                  end else begin
                     tx_scnt <= tx_scnt + 4'd1;
                  end
               end
            end
            TX_STOP: begin
               if (s_tick) begin
                  if (tx_scnt == LAST_TICK) begin
                     tx_scnt  <= '0;
                     tx_done  <= 1'b1;
                     tx_state <= TX_IDLE;
                  end else begin
                     tx_scnt <= tx_scnt + 4'd1;
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_alu_top.sv
// tb_uart_alu_top: drives serial byte triples into uart_alu_top and decodes
// the serial output, comparing against an arithmetic reference model.
module tb_uart_alu_top;

   localparam int TICK_DIV = 4;
   localparam int BIT_CYC  = TICK_DIV * 16;

`ifdef UART_ALU_SHIFT_OPS_EN
   localparam logic [7:0] EXP_SRA = 8'hFC;
   localparam logic [7:0] EXP_SRL = 8'h3C;
`else
   localparam logic [7:0] EXP_SRA = 8'h00;
   localparam logic [7:0] EXP_SRL = 8'h00;
`endif

   logic clk = 1'b0;
   logic reset;
   logic rx;
   logic tx;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] got_q[$];

   always #5 clk = ~clk;

   uart_alu_top #(.TICK_DIV(TICK_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .tx    (tx)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_alu(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] iop);
      int ua, ub, sa, sh, r;
      ua = int'(ia);
      ub = int'(ib);
      sa = (ua >= 128) ? ua - 256 : ua;
      sh = ub % 8;
      case (int'(iop) % 64)
         'h20: r = ua + ub;
         'h22: r = ua - ub;
         'h24: r = ua & ub;
         'h25: r = ua | ub;
         'h26: r = ua ^ ub;
         'h27: r = ~(ua | ub);
`ifdef UART_ALU_SHIFT_OPS_EN
         'h03: r = sa >>> sh;
         'h02: r = ua / (1 << sh);
`endif
         default: r = 0;
      endcase
      return 8'(r & 255);
   endfunction

   // Serial output decoder: samples mid-bit, queues each decoded byte
   initial begin
      logic [7:0] v;
      v = '0;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            repeat (BIT_CYC / 2 - 1) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT_CYC) @(negedge clk);
               v[i] = tx;
            end
            repeat (BIT_CYC) @(negedge clk);
            if (tx === 1'b1) got_q.push_back(v);
            else             got_q.push_back(8'hxx);
            repeat (BIT_CYC / 2 - 2) @(negedge clk);
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      rx = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (BIT_CYC) @(negedge clk);
      end
      rx = stop_bit;
      repeat (BIT_CYC) @(negedge clk);
      rx = 1'b1;
      repeat ($urandom_range(2, 20)) @(negedge clk);
   endtask

   task automatic wait_frames(input int n, input string tag);
      int c;
      c = 0;
      while (got_q.size() < n && c < 3000) begin
         @(negedge clk);
         c++;
      end
      if (got_q.size() < n) check({tag, "_timeout"}, got_q.size(), n);
   endtask

   task automatic run_triple(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] iop,
                             input logic [7:0] exp, input string tag);
      send_byte(ia, 1'b1);
      send_byte(ib, 1'b1);
      send_byte(iop, 1'b1);
      wait_frames(1, tag);
      if (got_q.size() > 0) check(tag, got_q.pop_front(), exp);
   endtask

   initial begin
      logic [5:0] ops[9];
      logic [7:0] ra, rb, rop;
      logic [1:0] hi;
      int idx, lows, c;

      ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02, 6'h00};
      reset = 1'b1;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_tx", tx, 1);
      reset = 1'b0;

      lows = 0;
      repeat (2000) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("idle_tx_low_cycles", lows, 0);
      check("idle_frames", got_q.size(), 0);

      run_triple(8'h05, 8'h03, 8'h20, 8'h08, "add");
      run_triple(8'h10, 8'h30, 8'h22, 8'hE0, "sub");
      run_triple(8'h7F, 8'h01, 8'h20, 8'h80, "add_wrap");
      run_triple(8'hF0, 8'h02, 8'h03, EXP_SRA, "sra");
      run_triple(8'hF0, 8'h02, 8'h02, EXP_SRL, "srl");
      run_triple(8'h0F, 8'h33, 8'hE4, 8'h03, "and_hi_bits");
      run_triple(8'h12, 8'h34, 8'h3F, 8'h00, "bad_op");

      send_byte(8'h55, 1'b0);
      run_triple(8'h01, 8'h02, 8'h20, 8'h03, "after_frame_err");
      repeat (1500) @(negedge clk);
      check("frame_err_extra", got_q.size(), 0);

      for (int k = 0; k < 8; k++) begin
         idx = $urandom_range(0, 8);
         hi  = 2'($urandom_range(0, 3));
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rop = (idx == 8) ? 8'($urandom) : {hi, ops[idx]};
         run_triple(ra, rb, rop, ref_alu(ra, rb, rop), $sformatf("rand%0d_op%02h", k, rop));
      end

      // Reset in the middle of an outgoing frame
      send_byte(8'h05, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h20, 1'b1);
      c = 0;
      while (tx === 1'b1 && c < 300) begin
         @(negedge clk);
         c++;
      end
      check("midtx_frame_started", tx, 0);
      repeat (150) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midtx_reset_tx", tx, 1);
      @(negedge clk);
      reset = 1'b0;
      repeat (800) @(negedge clk);
      got_q.delete();
      repeat (1000) @(negedge clk);
      check("post_reset_quiet", got_q.size(), 0);

      // Partial operand set dropped by reset
      send_byte(8'h44, 1'b1);
      repeat (50) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      run_triple(8'h0A, 8'h0B, 8'h20, 8'h15, "partial_discard");

      repeat (1500) @(negedge clk);
      check("trailing_frames", got_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
